// File: rtl/fpu_shift_pkg.sv
// Shared definitions for the normalising barrel shifter: mode encoding,
// shift-amount width and the mapping of barrel levels onto pipeline stages.
package fpu_shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } shift_mode_e;

  function automatic int shw_of(input int width);
    return $clog2(width) + 1;
  endfunction

  // First barrel level owned by a stage: level k lives in stage floor(k*stages/shw).
  function automatic int stage_lvl_lo(input int stage, input int shw, input int stages);
    return (stage * shw + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/norm_shifter_shift_stage.sv
// One pipeline slice of the barrel shifter: applies barrel levels
// LVL_LO..LVL_HI-1 combinationally and registers the result with its own valid.
module shift_stage
  import fpu_shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SHW    = 6,
  parameter int LVL_LO = 0,
  parameter int LVL_HI = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sticky,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic [SHW-1:0]   out_shamt,
  output logic [1:0]       out_mode
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sticky_q, sticky_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [1:0]       mode_q, mode_d;

  shift_mode_e      mode_e;
  logic [WIDTH-1:0] lvl_data;
  logic             lvl_sticky;
  logic             load;

  // Ready only looks at local occupancy and downstream ready, never at in_valid.
  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;
  assign mode_e   = shift_mode_e'(in_mode);

  always_comb begin
    lvl_data   = in_data;
    lvl_sticky = in_sticky;
    for (int k = LVL_LO; k < LVL_HI; k++) begin
      if (in_shamt[k]) begin
        case (mode_e)
          MODE_SLL: begin
            if ((1 << k) >= WIDTH) lvl_data = '0;
            else                   lvl_data = lvl_data << (1 << k);
          end
          MODE_SRL: begin
            if ((1 << k) >= WIDTH) begin
              lvl_sticky = lvl_sticky | (|lvl_data);
              lvl_data   = '0;
            end else begin
              lvl_sticky = lvl_sticky | (|(lvl_data & ~(ONES << (1 << k))));
              lvl_data   = lvl_data >> (1 << k);
            end
          end
          MODE_SRA: begin
            // Sign copies shifted out later equal the original MSB, so the OR is unaffected.
            if ((1 << k) >= WIDTH) begin
              lvl_sticky = lvl_sticky | (|lvl_data);
              lvl_data   = {WIDTH{lvl_data[WIDTH-1]}};
            end else begin
              lvl_sticky = lvl_sticky | (|(lvl_data & ~(ONES << (1 << k))));
              lvl_data   = $signed(lvl_data) >>> (1 << k);
            end
          end
          default: begin
            if ((1 << k) < WIDTH)
              lvl_data = (lvl_data << (1 << k)) | (lvl_data >> (WIDTH - (1 << k)));
          end
        endcase
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    sticky_d = sticky_q;
    shamt_d  = shamt_q;
    mode_d   = mode_q;
    if (load) begin
      valid_d  = 1'b1;
      data_d   = lvl_data;
      sticky_d = lvl_sticky;
      shamt_d  = in_shamt;
      mode_d   = in_mode;
    end else if (out_ready) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      sticky_q <= 1'b0;
      shamt_q  <= '0;
      mode_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      sticky_q <= sticky_d;
      shamt_q  <= shamt_d;
      mode_q   <= mode_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_sticky = sticky_q;
  assign out_shamt  = shamt_q;
  assign out_mode   = mode_q;

endmodule

// File: rtl/norm_shifter.sv
// Pipelined log-depth barrel shifter (SLL/SRL/SRA/ROL) with right-shift sticky
// output and valid/ready flow control on both sides.
module norm_shifter
  import fpu_shift_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [$clog2(WIDTH):0] in_shamt,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_sticky
);

  localparam int SHW = shw_of(WIDTH);

  // Element s feeds stage s; element PIPE_STAGES is the block output.
  logic             v_chain [0:PIPE_STAGES];
  logic             r_chain [0:PIPE_STAGES];
  logic [WIDTH-1:0] d_chain [0:PIPE_STAGES];
  logic             s_chain [0:PIPE_STAGES];
  logic [SHW-1:0]   a_chain [0:PIPE_STAGES];
  logic [1:0]       m_chain [0:PIPE_STAGES];

  assign v_chain[0]           = in_valid;
  assign d_chain[0]           = in_data;
  assign s_chain[0]           = 1'b0;
  assign a_chain[0]           = in_shamt;
  assign m_chain[0]           = in_mode;
  assign r_chain[PIPE_STAGES] = out_ready;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    shift_stage #(
      .WIDTH  (WIDTH),
      .SHW    (SHW),
      .LVL_LO (stage_lvl_lo(s, SHW, PIPE_STAGES)),
      .LVL_HI (stage_lvl_lo(s + 1, SHW, PIPE_STAGES))
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (v_chain[s]),
      .in_ready   (r_chain[s]),
      .in_data    (d_chain[s]),
      .in_sticky  (s_chain[s]),
      .in_shamt   (a_chain[s]),
      .in_mode    (m_chain[s]),
      .out_valid  (v_chain[s+1]),
      .out_ready  (r_chain[s+1]),
      .out_data   (d_chain[s+1]),
      .out_sticky (s_chain[s+1]),
      .out_shamt  (a_chain[s+1]),
      .out_mode   (m_chain[s+1])
    );
  end

  assign in_ready   = r_chain[0];
  assign out_valid  = v_chain[PIPE_STAGES];
  assign out_data   = d_chain[PIPE_STAGES];
  assign out_sticky = s_chain[PIPE_STAGES];

endmodule

// File: tb/tb_norm_shifter.sv
// Scoreboard bench for norm_shifter (WIDTH=32, PIPE_STAGES=2): directed vectors,
// stalled stream, asynchronous reset with work in flight, and a random soak.
module tb_norm_shifter;

  localparam int WIDTH = 32;
  localparam int PIPE  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_shamt;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sticky;

  always #5 clk = ~clk;

  norm_shifter #(.WIDTH(WIDTH), .PIPE_STAGES(PIPE)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky)
  );

  typedef struct {
    logic [31:0] data;
    logic        sticky;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    logic [5:0]  shamt;
    logic [31:0] exp_data;
    logic        exp_sticky;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   rand_done;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [1:0] mode, input logic [31:0] d,
                                        input logic [5:0] sh);
    logic [31:0] r;
    logic        st;
    int          n;
    int          m;
    n  = int'(sh);
    m  = n % 32;
    st = 1'b0;
    case (mode)
      2'd0:    r = (n >= 32) ? 32'h0 : d << n;
      2'd1:    r = (n >= 32) ? 32'h0 : d >> n;
      2'd2:    r = (n >= 32) ? {32{d[31]}} : 32'($signed(d) >>> n);
      default: r = (m == 0) ? d : ((d << m) | (d >> (32 - m)));
    endcase
    if (mode == 2'd1 || mode == 2'd2)
      st = (n >= 32) ? |d : |(d & ((32'h1 << n) - 32'h1));
    return {st, r};
  endfunction

  function automatic vec_t mk(input logic [1:0] m, input logic [31:0] d, input logic [5:0] s,
                              input logic [31:0] ed, input logic es);
    vec_t v;
    v.mode = m; v.data = d; v.shamt = s; v.exp_data = ed; v.exp_sticky = es;
    return v;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] m, input logic [31:0] d, input logic [5:0] s,
                      input logic [31:0] ed, input logic es, input bit lat);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    in_shamt = s;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
      in_valid = 1'b0;
      return;
    end
    e.data = ed; e.sticky = es; e.acc_cyc = cyc; e.chk_lat = lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: pops on every output handshake, and checks hold-stability during stalls.
  initial begin
    exp_t        e;
    logic [31:0] hold_data;
    logic        hold_sticky;
    bit          holding;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0;
      end else begin
        if (holding && out_valid) begin
          check("stall_hold_data", 64'(out_data), 64'(hold_data));
          check("stall_hold_sticky", 64'(out_sticky), 64'(hold_sticky));
        end
        holding = 1'b0;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got result 0x%0h, expected no output", out_data);
          end else begin
            e = sb_q.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_sticky", 64'(out_sticky), 64'(e.sticky));
            if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'(PIPE));
          end
        end else if (out_valid) begin
          holding     = 1'b1;
          hold_data   = out_data;
          hold_sticky = out_sticky;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] r;
    logic [1:0]  rm;
    logic [31:0] rd;
    logic [5:0]  rs;
    bit          saw_block;

    vecs.push_back(mk(2'd0, 32'h0000_0001, 6'd31, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(2'd1, 32'h0000_00FF, 6'd4,  32'h0000_000F, 1'b1));
    vecs.push_back(mk(2'd1, 32'h0000_00FF, 6'd40, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(2'd2, 32'h8000_0010, 6'd4,  32'hF800_0001, 1'b0));
    vecs.push_back(mk(2'd3, 32'h8000_0001, 6'd33, 32'h0000_0003, 1'b0));
    vecs.push_back(mk(2'd2, 32'h8000_0000, 6'd63, 32'hFFFF_FFFF, 1'b1));
    vecs.push_back(mk(2'd0, 32'hFFFF_FFFF, 6'd32, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(2'd3, 32'h1234_5678, 6'd0,  32'h1234_5678, 1'b0));
    vecs.push_back(mk(2'd1, 32'h1234_5678, 6'd0,  32'h1234_5678, 1'b0));
    vecs.push_back(mk(2'd2, 32'h7000_0000, 6'd40, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(2'd2, 32'h8000_0000, 6'd31, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(2'd3, 32'h1234_5678, 6'd4,  32'h2345_6781, 1'b0));
    vecs.push_back(mk(2'd1, 32'h0000_0010, 6'd5,  32'h0000_0000, 1'b1));
    vecs.push_back(mk(2'd0, 32'h0000_00F0, 6'd63, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(2'd3, 32'h8000_0000, 6'd63, 32'h4000_0000, 1'b0));

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; out_ready = 1'b1;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_sticky", 64'(out_sticky), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors back-to-back with out_ready high: fixed latency, full rate.
    foreach (vecs[i])
      send(vecs[i].mode, vecs[i].data, vecs[i].shamt, vecs[i].exp_data, vecs[i].exp_sticky, 1'b1);
    drain();

    // Six-request stream with a three-cycle output stall.
    @(posedge clk);
    #1;
    saw_block = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(vecs[i].mode, vecs[i].data, vecs[i].shamt, vecs[i].exp_data, vecs[i].exp_sticky, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        repeat (8) begin
          @(negedge clk);
          if (!in_ready) saw_block = 1'b1;
        end
      end
    join
    check("in_ready_dropped_when_full", 64'(saw_block), 64'd1);
    drain();

    // Asynchronous reset with two requests in flight.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(vecs[1].mode, vecs[1].data, vecs[1].shamt, vecs[1].exp_data, vecs[1].exp_sticky, 1'b0);
    send(vecs[3].mode, vecs[3].data, vecs[3].shamt, vecs[3].exp_data, vecs[3].exp_sticky, 1'b0);
    #2;
    check("inflight_before_reset", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("async_reset_out_valid", 64'(out_valid), 64'd0);
    check("async_reset_out_data", 64'(out_data), 64'd0);
    check("async_reset_out_sticky", 64'(out_sticky), 64'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after_async_reset", 64'(in_ready), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("no_stale_result", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Random soak with random output back-pressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          rm = 2'($urandom_range(0, 3));
          rd = $urandom;
          rs = 6'($urandom_range(0, 63));
          r  = model(rm, rd, rs);
          send(rm, rd, rs, r[31:0], r[32], 1'b0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
